onehot_grant_dispatcher: RTL and testbench

Accepts a 3-bit request code with a valid/ready handshake and converts it back into a one-hot grant on lines 7..1. It holds the grant until the addressed line acknowledges it or a programmable timeout expires. It sits downstream of the team's 7-input priority encoder and closes the request/grant loop: the encoder names the highest-priority requester, and this block grants that requester. Code 0 means "no request" and never produces a grant.

---
 rtl/onehot_grant_dispatcher.sv | 108 ++++++++++
 tb/tb_onehot_grant_dispatcher.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_grant_dispatcher.sv
// Converts a 3-bit request code into a held one-hot grant on lines 7..1,
// released by the addressed line's acknowledge or by a programmable timeout.
module onehot_grant_dispatcher #(
  parameter int TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       code_valid,
  input  logic [2:0] code,
  output logic       code_ready,
  input  logic [7:1] ack,
  output logic [7:1] grant,
  output logic       busy,
  output logic       timeout,
  output logic       spurious_ack,
  output logic [7:0] grant_count
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANT   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]    state_q,    state_d;
  logic [2:0]    code_q,     code_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [7:1]    grant_q,    grant_d;
  logic          timeout_q,  timeout_d;
  logic          spurious_q, spurious_d;
  logic [7:0]    count_q,    count_d;

  // Bit 0 pads the vector so the latched code indexes its own line directly.
  logic [7:0] ack_line;
  assign ack_line = {ack, 1'b0};

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    timeout_d  = 1'b0;
    spurious_d = 1'b0;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        // A zero code is consumed here but never turns into a grant.
        if (code_valid && (code != 3'd0)) begin
          code_d  = code;
          grant_d = 7'b1 << (code - 3'd1);
          cnt_d   = CW'(TIMEOUT - 1);
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        spurious_d = |(ack & ~grant_q);
        // Acknowledge wins over expiry on the final grant cycle.
        if (ack_line[code_q]) begin
          grant_d = '0;
          count_d = count_q + 8'd1;
          state_d = S_RELEASE;
        end else if (cnt_q == '0) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          count_d   = count_q + 8'd1;
          state_d   = S_RELEASE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      code_q     <= 3'd0;
      cnt_q      <= '0;
      grant_q    <= '0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
      count_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
      count_q    <= count_d;
    end
  end

  assign code_ready   = (state_q == S_IDLE);
  assign busy         = (state_q == S_GRANT) || (state_q == S_RELEASE);
  assign grant        = grant_q;
  assign timeout      = timeout_q;
  assign spurious_ack = spurious_q;
  assign grant_count  = count_q;

endmodule

// File: tb/tb_onehot_grant_dispatcher.sv
// Directed bench for onehot_grant_dispatcher with TIMEOUT=4.
module tb_onehot_grant_dispatcher;

  logic       clk;
  logic       reset_n;
  logic       code_valid;
  logic [2:0] code;
  logic       code_ready;
  logic [7:1] ack;
  logic [7:1] grant;
  logic       busy;
  logic       timeout;
  logic       spurious_ack;
  logic [7:0] grant_count;

  int checks = 0;
  int errors = 0;

  onehot_grant_dispatcher #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .code_valid   (code_valid),
    .code         (code),
    .code_ready   (code_ready),
    .ack          (ack),
    .grant        (grant),
    .busy         (busy),
    .timeout      (timeout),
    .spurious_ack (spurious_ack),
    .grant_count  (grant_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    code_valid = 1'b0;
    code       = 3'd0;
    ack        = 7'h00;
    #2;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_ready", 32'(code_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);
    chk("rst_spur", 32'(spurious_ack), 32'h0);
    chk("rst_count", 32'(grant_count), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;

    // code 5, no ack: four grant cycles then a timeout pulse
    code_valid = 1'b1;
    code       = 3'd5;
    tick();
    code_valid = 1'b0;
    code       = 3'd0;
    chk("t1_ready", 32'(code_ready), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("t1_grant", 32'(grant), 32'h10);
      chk("t1_no_to", 32'(timeout), 32'h0);
      tick();
    end
    chk("t1_rel_grant", 32'(grant), 32'h0);
    chk("t1_timeout", 32'(timeout), 32'h1);
    chk("t1_count", 32'(grant_count), 32'h1);
    chk("t1_rel_ready", 32'(code_ready), 32'h0);
    chk("t1_rel_busy", 32'(busy), 32'h1);
    tick();
    chk("t1_to_pulse", 32'(timeout), 32'h0);
    chk("t1_ready_back", 32'(code_ready), 32'h1);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // code 7, ack in the first grant cycle
    code_valid = 1'b1;
    code       = 3'd7;
    tick();
    code_valid = 1'b0;
    chk("t2_grant", 32'(grant), 32'h40);
    ack = 7'h40;
    tick();
    ack = 7'h00;
    chk("t2_rel_grant", 32'(grant), 32'h0);
    chk("t2_timeout", 32'(timeout), 32'h0);
    chk("t2_count", 32'(grant_count), 32'h2);
    tick();
    chk("t2_ready", 32'(code_ready), 32'h1);

    // code 3, ack on the last grant cycle: no timeout
    code_valid = 1'b1;
    code       = 3'd3;
    tick();
    code_valid = 1'b0;
    chk("t3_grant_c1", 32'(grant), 32'h04);
    tick();
    tick();
    tick();
    chk("t3_grant_c4", 32'(grant), 32'h04);
    ack = 7'h04;
    tick();
    ack = 7'h00;
    chk("t3_rel_grant", 32'(grant), 32'h0);
    chk("t3_timeout", 32'(timeout), 32'h0);
    chk("t3_count", 32'(grant_count), 32'h3);
    tick();

    // code 2 with a foreign ack on line 6
    code_valid = 1'b1;
    code       = 3'd2;
    tick();
    code_valid = 1'b0;
    chk("t4_grant_c1", 32'(grant), 32'h02);
    chk("t4_no_spur", 32'(spurious_ack), 32'h0);
    ack = 7'h20;
    tick();
    ack = 7'h00;
    chk("t4_spur", 32'(spurious_ack), 32'h1);
    chk("t4_grant_c2", 32'(grant), 32'h02);
    tick();
    chk("t4_spur_pulse", 32'(spurious_ack), 32'h0);
    chk("t4_grant_c3", 32'(grant), 32'h02);
    tick();
    chk("t4_grant_c4", 32'(grant), 32'h02);
    tick();
    chk("t4_timeout", 32'(timeout), 32'h1);
    chk("t4_count", 32'(grant_count), 32'h4);
    tick();

    // code 0 dropped, then code 1 granted
    code_valid = 1'b1;
    code       = 3'd0;
    tick();
    chk("t5_zero_ready", 32'(code_ready), 32'h1);
    chk("t5_zero_grant", 32'(grant), 32'h0);
    chk("t5_zero_count", 32'(grant_count), 32'h4);
    chk("t5_zero_busy", 32'(busy), 32'h0);
    code = 3'd1;
    tick();
    code_valid = 1'b0;
    chk("t5_grant", 32'(grant), 32'h01);
    ack = 7'h01;
    tick();
    ack = 7'h00;
    chk("t5_count", 32'(grant_count), 32'h5);
    tick();

    // back-to-back grants on line 4 until the count wraps
    code_valid = 1'b1;
    code       = 3'd4;
    ack        = 7'h08;
    for (int g = 1; g <= 251; g++) begin
      tick();
      chk("t6_grant", 32'(grant), 32'h08);
      tick();
      chk("t6_count", 32'(grant_count), 32'((5 + g) % 256));
      chk("t6_no_to", 32'(timeout), 32'h0);
      tick();
      chk("t6_ready", 32'(code_ready), 32'h1);
    end
    chk("t6_wrapped", 32'(grant_count), 32'h0);
    tick();
    chk("t6_grant_again", 32'(grant), 32'h08);
    chk("t6_count_one", 32'(grant_count), 32'h0);

    // asynchronous reset mid-grant
    #2;
    reset_n = 1'b0;
    #1;
    chk("t7_grant", 32'(grant), 32'h0);
    chk("t7_count", 32'(grant_count), 32'h0);
    chk("t7_ready", 32'(code_ready), 32'h1);
    chk("t7_busy", 32'(busy), 32'h0);
    tick();
    chk("t7_no_to", 32'(timeout), 32'h0);
    code_valid = 1'b1;
    code       = 3'd6;
    ack        = 7'h00;
    reset_n    = 1'b1;
    tick();
    chk("t7_post_grant", 32'(grant), 32'h20);
    chk("t7_post_busy", 32'(busy), 32'h1);
    code_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
